// File: rtl/me_pkg.sv
// Shared constants and width helpers for the motion-estimation SAD engine.
package me_pkg;

    localparam int DEF_ELEMENT_BIT_DEPTH = 14;
    localparam int DEF_ROWS              = 8;
    localparam int DEF_CANDIDATES        = 16;

    // The adder tree always has eight inputs, one per pixel of a row.
    localparam int LANES = 8;

    // Block SAD width: one row sum plus enough headroom for ROWS of them.
    function automatic int calc_sad_w(input int ebd, input int rows);
        return ebd + $clog2(rows);
    endfunction

    // Candidate index width.
    function automatic int calc_idx_w(input int candidates);
        return $clog2(candidates);
    endfunction

endpackage

// File: rtl/sad_row_accum_ctrl_if.sv
// Row-in / block-SAD-out handshake bundle for the SAD row accumulator.
interface sad_row_accum_ctrl_if #(
    parameter int ELEMENT_BIT_DEPTH = me_pkg::DEF_ELEMENT_BIT_DEPTH,
    parameter int SAD_W = me_pkg::calc_sad_w(me_pkg::DEF_ELEMENT_BIT_DEPTH, me_pkg::DEF_ROWS),
    parameter int IDX_W = me_pkg::calc_idx_w(me_pkg::DEF_CANDIDATES)
);

    logic                                       in_valid;
    logic                                       in_ready;
    logic [me_pkg::LANES*ELEMENT_BIT_DEPTH-1:0] in_row;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [SAD_W-1:0]                           out_sad;
    logic [IDX_W-1:0]                           out_idx;
    logic                                       out_last;

    // Environment side: supplies rows and consumes results.
    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_sad, out_idx, out_last
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_sad, out_idx, out_last
    );

endinterface

// File: rtl/sad_min_tracker.sv
// Running minimum of block SADs across one search window; candidate 0 restarts it.
module sad_min_tracker #(
    parameter int SAD_W = 17,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SAD_W-1:0] sad,
    input  logic [IDX_W-1:0] idx,
    output logic [SAD_W-1:0] best_sad,
    output logic [IDX_W-1:0] best_idx
);

    // Take the first candidate unconditionally, later ones only if strictly smaller so ties keep the earlier index.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_sad <= '0;
            best_idx <= '0;
        end else if (load) begin
            if ((idx == '0) || (sad < best_sad)) begin
                best_sad <= sad;
                best_idx <= idx;
            end
        end
    end

endmodule

// File: rtl/sad_row_accum_ctrl.sv
// Sequencer for the 8-input SAD adder tree: registers rows onto the tree,
// accumulates row sums into block SADs and tracks the window minimum.
module sad_row_accum_ctrl
    import me_pkg::*;
#(
    parameter int ELEMENT_BIT_DEPTH = DEF_ELEMENT_BIT_DEPTH,
    parameter int ROWS              = DEF_ROWS,
    parameter int CANDIDATES        = DEF_CANDIDATES,
    localparam int SAD_W            = calc_sad_w(ELEMENT_BIT_DEPTH, ROWS),
    localparam int IDX_W            = calc_idx_w(CANDIDATES)
) (
    input  logic                               clk,
    input  logic                               rst,
    sad_row_accum_ctrl_if.slave                bus,
    output logic [LANES*ELEMENT_BIT_DEPTH-1:0] tree_addend,
    input  logic [ELEMENT_BIT_DEPTH-1:0]       tree_sum,
    output logic [SAD_W-1:0]                   best_sad,
    output logic [IDX_W-1:0]                   best_idx
);

    localparam int ROW_W = $clog2(ROWS);

    logic             s1_valid;
    logic             s1_last;
    logic             s1_first;
    logic [ROW_W-1:0] row_cnt;
    logic [IDX_W-1:0] cand_cnt;
    logic [SAD_W-1:0] acc;
    logic [SAD_W-1:0] sum;
    logic             s1_adv;
    logic             accept;
    logic             result_load;

    // The last row of a block may only leave stage 1 once the output register is free or being drained.
    always_comb begin
        s1_adv      = s1_valid && !(s1_last && bus.out_valid && !bus.out_ready);
        accept      = bus.in_valid && bus.in_ready;
        result_load = s1_adv && s1_last;
        sum         = (s1_first ? '0 : acc) + SAD_W'(tree_sum);
    end

    assign bus.in_ready = !s1_valid || s1_adv;

    // Stage 1: hold the accepted row on the adder-tree inputs and remember its position in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            tree_addend <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_first    <= 1'b0;
            row_cnt     <= '0;
        end else if (accept) begin
            tree_addend <= bus.in_row;
            s1_valid    <= 1'b1;
            s1_last     <= (row_cnt == ROW_W'(ROWS - 1));
            s1_first    <= (row_cnt == '0);
            row_cnt     <= (row_cnt == ROW_W'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: fold each row sum into the accumulator and publish the block SAD on the last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cand_cnt     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sad   <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (s1_adv && !s1_last) begin
                acc <= sum;
            end
            if (result_load) begin
                acc           <= '0;
                bus.out_sad   <= sum;
                bus.out_idx   <= cand_cnt;
                bus.out_last  <= (cand_cnt == IDX_W'(CANDIDATES - 1));
                bus.out_valid <= 1'b1;
                cand_cnt      <= (cand_cnt == IDX_W'(CANDIDATES - 1)) ? '0 : cand_cnt + 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

    sad_min_tracker #(
        .SAD_W (SAD_W),
        .IDX_W (IDX_W)
    ) u_min_tracker (
        .clk      (clk),
        .rst      (rst),
        .load     (result_load),
        .sad      (sum),
        .idx      (cand_cnt),
        .best_sad (best_sad),
        .best_idx (best_idx)
    );

endmodule

// File: tb/tb_sad_row_accum_ctrl.sv
// Directed self-checking bench for sad_row_accum_ctrl with a behavioural 8-input adder tree.
module tb_sad_row_accum_ctrl;

    localparam int EBD = 14;
    localparam int SW  = 17;
    localparam int IW  = 4;

    typedef struct packed {
        logic [SW-1:0] sad;
        logic [IW-1:0] idx;
        logic          last;
    } res_t;

    typedef struct {
        logic [EBD-1:0] base;
        logic [EBD-1:0] step;
        logic [SW-1:0]  exp_sad;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [8*EBD-1:0] tree_addend;
    logic [EBD-1:0] tree_sum;
    logic [SW-1:0]  best_sad;
    logic [IW-1:0]  best_idx;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t results[$];
    vec_t vecs[5];

    sad_row_accum_ctrl_if bus ();

    sad_row_accum_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tree_addend (tree_addend),
        .tree_sum    (tree_sum),
        .best_sad    (best_sad),
        .best_idx    (best_idx)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder tree: eight lanes summed modulo 2^EBD.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < 8; i++) tree_sum = tree_sum + tree_addend[i*EBD +: EBD];
    end

    // Record every completed output handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            results.push_back('{sad: bus.out_sad, idx: bus.out_idx, last: bus.out_last});
    end

    // Hard stop in case the flow wedges somewhere unexpected.
    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    function automatic logic [8*EBD-1:0] make_row(input logic [EBD-1:0] base, input logic [EBD-1:0] step);
        logic [8*EBD-1:0] r;
        for (int i = 0; i < 8; i++) r[i*EBD +: EBD] = base + EBD'(i) * step;
        return r;
    endfunction

    function automatic logic [8*EBD-1:0] make_lane0(input logic [EBD-1:0] v);
        logic [8*EBD-1:0] r;
        r = '0;
        r[EBD-1:0] = v;
        return r;
    endfunction

    // Offer one row and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic apply_stimulus(input logic [8*EBD-1:0] row);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check_output("in_ready_wait", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [8*EBD-1:0] row);
        for (int r = 0; r < 8; r++) apply_stimulus(row);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        results.delete();
    endtask

    // Wait (bounded) for n results, let things settle, then confirm no extra ones appeared.
    task automatic wait_results(input int n, input string name);
        int cyc = 0;
        while (results.size() < n && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_output(name, 64'(results.size()), 64'(n));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{base: 14'd1,     step: 14'd0, exp_sad: 17'd64};
        vecs[1] = '{base: 14'd0,     step: 14'd1, exp_sad: 17'd224};
        vecs[2] = '{base: 14'd16383, step: 14'd0, exp_sad: 17'd131008};
        vecs[3] = '{base: 14'd100,   step: 14'd3, exp_sad: 17'd7072};
        vecs[4] = '{base: 14'd0,     step: 14'd0, exp_sad: 17'd0};

        // Reset state.
        do_reset();
        @(negedge clk);
        check_output("rst_in_ready",    64'(bus.in_ready),  64'd1);
        check_output("rst_out_valid",   64'(bus.out_valid), 64'd0);
        check_output("rst_out_last",    64'(bus.out_last),  64'd0);
        check_output("rst_out_sad",     64'(bus.out_sad),   64'd0);
        check_output("rst_out_idx",     64'(bus.out_idx),   64'd0);
        check_output("rst_best_sad",    64'(best_sad),      64'd0);
        check_output("rst_best_idx",    64'(best_idx),      64'd0);
        check_output("rst_tree_addend", 64'(tree_addend[63:0]), 64'd0);
        @(posedge clk);
        #1;

        // All-ones block: result appears exactly one edge after the eighth accept.
        send_block(make_row(14'd1, 14'd0));
        check_output("lat_not_early", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_output("lat_valid", 64'(bus.out_valid), 64'd1);
        check_output("lat_sad",   64'(bus.out_sad),   64'd64);
        check_output("lat_idx",   64'(bus.out_idx),   64'd0);
        @(posedge clk);
        #1;
        check_output("lat_drop",  64'(bus.out_valid), 64'd0);

        // Table of uniform/ramp/max-element blocks, back to back.
        do_reset();
        for (int v = 0; v < 5; v++) send_block(make_row(vecs[v].base, vecs[v].step));
        wait_results(5, "tbl_count");
        for (int v = 0; v < 5 && v < results.size(); v++) begin
            check_output($sformatf("tbl_sad_%0d", v), 64'(results[v].sad), 64'(vecs[v].exp_sad));
            check_output($sformatf("tbl_idx_%0d", v), 64'(results[v].idx), 64'(v));
        end
        check_output("tbl_best_sad", 64'(best_sad), 64'd0);
        check_output("tbl_best_idx", 64'(best_idx), 64'd4);

        // Full window of 16 candidates; minimum at candidate 9.
        do_reset();
        for (int k = 0; k < 16; k++)
            send_block(make_lane0((k < 10) ? EBD'(100 - k) : 14'd200));
        wait_results(16, "win_count");
        for (int k = 0; k < 16 && k < results.size(); k++) begin
            check_output($sformatf("win_sad_%0d", k),  64'(results[k].sad),  64'((k < 10) ? 8 * (100 - k) : 1600));
            check_output($sformatf("win_idx_%0d", k),  64'(results[k].idx),  64'(k));
            check_output($sformatf("win_last_%0d", k), 64'(results[k].last), 64'(k == 15));
        end
        check_output("win_best_sad", 64'(best_sad), 64'd728);
        check_output("win_best_idx", 64'(best_idx), 64'd9);
        send_block(make_lane0(14'd150));
        wait_results(17, "win2_count");
        check_output("win2_best_sad", 64'(best_sad), 64'd1200);
        check_output("win2_best_idx", 64'(best_idx), 64'd0);

        // Backpressure: two blocks stream in while the result is not taken.
        do_reset();
        bus.out_ready = 1'b0;
        send_block(make_lane0(14'd10));
        send_block(make_lane0(14'd20));
        @(negedge clk);
        check_output("bp_in_ready",  64'(bus.in_ready),  64'd0);
        check_output("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check_output("bp_out_sad",   64'(bus.out_sad),   64'd80);
        repeat (4) @(negedge clk);
        check_output("bp_hold_sad",  64'(bus.out_sad),   64'd80);
        check_output("bp_hold_idx",  64'(bus.out_idx),   64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_results(2, "bp_count");
        if (results.size() >= 2) begin
            check_output("bp_first_sad",  64'(results[0].sad), 64'd80);
            check_output("bp_second_sad", 64'(results[1].sad), 64'd160);
            check_output("bp_second_idx", 64'(results[1].idx), 64'd1);
        end
        check_output("bp_final_valid", 64'(bus.out_valid), 64'd0);

        // Equal minima at candidates 3 and 7: the earlier index wins.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) begin
                apply_stimulus(make_lane0(14'd43));
                for (int r = 1; r < 8; r++) apply_stimulus(make_lane0(14'd1));
            end else begin
                send_block(make_lane0(14'd10));
            end
        end
        wait_results(8, "tie_count");
        if (results.size() >= 8) begin
            check_output("tie_sad_3", 64'(results[3].sad), 64'd50);
            check_output("tie_sad_7", 64'(results[7].sad), 64'd50);
        end
        check_output("tie_best_sad", 64'(best_sad), 64'd50);
        check_output("tie_best_idx", 64'(best_idx), 64'd3);

        // Reset in the middle of candidate 2 discards the partial block.
        do_reset();
        send_block(make_lane0(14'd5));
        send_block(make_lane0(14'd5));
        wait_results(2, "mid_pre_count");
        for (int r = 0; r < 6; r++) apply_stimulus(make_lane0(14'd9));
        do_reset();
        @(negedge clk);
        check_output("mid_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("mid_in_ready",  64'(bus.in_ready),  64'd1);
        repeat (5) @(posedge clk);
        #1;
        check_output("mid_no_output", 64'(results.size()), 64'd0);
        send_block(make_lane0(14'd7));
        wait_results(1, "mid_post_count");
        if (results.size() >= 1) begin
            check_output("mid_post_sad", 64'(results[0].sad), 64'd56);
            check_output("mid_post_idx", 64'(results[0].idx), 64'd0);
        end
        check_output("mid_best_sad", 64'(best_sad), 64'd56);
        check_output("mid_best_idx", 64'(best_idx), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
